// File: rtl/display_source_mux.sv
// -----------------------------------------------------------------------------
// display_source_mux
//
// Frame-synchronised selector between NUM_SRC display producers (menu, volume
// bar, games, end screens) and the OLED / 7-segment drivers. A new select code
// is never applied mid-frame: the change is held until the next frame_begin,
// then (for a source-to-source switch) BLANK_FRAMES full frames of blank output
// are inserted before the new source appears. Entering or leaving the locked
// screen skips the blank frames.
//
// Optional feature (compile-time macro DISPLAY_FADE_EN):
//   defined   - during blank frames oled_data is the outgoing source's pixel
//               with each RGB565 channel right-shifted by
//               BLANK_FRAMES - counter + 1 (a fade towards black);
//               an/seg stay blank.
//   undefined - blank frames are plain black.
//   The port list is identical in both builds.
//
// Ports:
//   clk          in   1          system clock
//   reset        in   1          synchronous, active-high reset
//   sel          in   SEL_W      requested source code
//   frame_begin  in   1          one-cycle pulse on the first pixel of a frame
//   oled_in      in   16*NUM_SRC RGB565 pixel per source, source i at [16i+15:16i]
//   an_in        in   4*NUM_SRC  anode pattern per source, source i at [4i+3:4i]
//   seg_in       in   8*NUM_SRC  segment pattern per source, source i at [8i+7:8i]
//   oled_data    out  16         selected pixel (registered)
//   an           out  4          selected anodes, active-low (registered)
//   seg          out  8          selected segments, active-low (registered)
//   active_src   out  SEL_W      code currently displayed (registered)
//   switching    out  1          change pending or blanking (registered)
//   sel_err      out  1          sel is neither a source nor LOCK_CODE (registered)
// -----------------------------------------------------------------------------
module display_source_mux #(
  parameter int                 NUM_SRC      = 10,
  parameter int                 SEL_W        = 4,
  parameter logic [SEL_W-1:0]   LOCK_CODE    = {SEL_W{1'b1}},
  parameter int                 BLANK_FRAMES = 2,
  parameter logic [NUM_SRC-1:0] SEG_OFF_MASK = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  frame_begin,
  input  logic [16*NUM_SRC-1:0] oled_in,
  input  logic [4*NUM_SRC-1:0]  an_in,
  input  logic [8*NUM_SRC-1:0]  seg_in,
  output logic [15:0]           oled_data,
  output logic [3:0]            an,
  output logic [7:0]            seg,
  output logic [SEL_W-1:0]      active_src,
  output logic                  switching,
  output logic                  sel_err
);

  // Counter must hold BLANK_FRAMES; keep at least one bit when it is 0.
  localparam int CNT_W = (BLANK_FRAMES < 1) ? 1 : $clog2(BLANK_FRAMES + 1);

  localparam logic [SEL_W:0]   NUM_SRC_C    = (SEL_W + 1)'(NUM_SRC);
  localparam logic [CNT_W-1:0] BLANK_LOAD   = CNT_W'(BLANK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [15:0]      BLANK_PIXEL  = 16'h0000;
  localparam logic [3:0]       BLANK_ANODES = 4'b1111;
  localparam logic [7:0]       BLANK_SEGS   = 8'hFF;

  typedef enum logic [1:0] {
    ST_LOCKED     = 2'd0,
    ST_SHOW       = 2'd1,
    ST_WAIT_FRAME = 2'd2,
    ST_BLANK      = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t             state_reg,     state_next;
  logic [SEL_W-1:0]   active_reg,    active_next;
  logic [SEL_W-1:0]   pending_reg,   pending_next;
  logic [CNT_W-1:0]   cnt_reg,       cnt_next;
  logic [15:0]        oled_reg,      oled_next;
  logic [3:0]         an_reg,        an_next;
  logic [7:0]         seg_reg,       seg_next;
  logic               switching_reg, switching_next;
  logic               sel_err_reg,   sel_err_next;

  // ---------------------------------------------------------------------------
  // Per-source views of the packed input buses
  // ---------------------------------------------------------------------------
  logic [15:0] src_pix [NUM_SRC];
  logic [3:0]  src_an  [NUM_SRC];
  logic [7:0]  src_seg [NUM_SRC];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_pix[gi] = oled_in[16*gi +: 16];
      assign src_an[gi]  = an_in[4*gi +: 4];
      assign src_seg[gi] = seg_in[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Select-code qualification
  // ---------------------------------------------------------------------------
  logic             sel_valid;
  logic [SEL_W-1:0] target;

  assign sel_valid = ({1'b0, sel} < NUM_SRC_C) || (sel == LOCK_CODE);
  // Target for a commit on this very cycle: a valid sel seen together with
  // frame_begin wins over the previously recorded pending code.
  assign target    = sel_valid ? sel : pending_reg;

`ifdef DISPLAY_FADE_EN
  // Right-shift each RGB565 channel by 'shift'; large shifts clear the pixel.
  function automatic logic [15:0] fade_pixel(input logic [15:0] pix, input int shift);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    if (shift >= 6) begin
      fade_pixel = 16'h0000;
    end else begin
      r = pix[15:11] >> shift;
      g = pix[10:5]  >> shift;
      b = pix[4:0]   >> shift;
      fade_pixel = {r, g, b};
    end
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_LOCKED;
      active_reg    <= LOCK_CODE;
      pending_reg   <= LOCK_CODE;
      cnt_reg       <= '0;
      oled_reg      <= BLANK_PIXEL;
      an_reg        <= BLANK_ANODES;
      seg_reg       <= BLANK_SEGS;
      switching_reg <= 1'b0;
      sel_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      active_reg    <= active_next;
      pending_reg   <= pending_next;
      cnt_reg       <= cnt_next;
      oled_reg      <= oled_next;
      an_reg        <= an_next;
      seg_reg       <= seg_next;
      switching_reg <= switching_next;
      sel_err_reg   <= sel_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    active_next  = active_reg;
    pending_next = pending_reg;
    cnt_next     = cnt_reg;

    case (state_reg)
      ST_LOCKED: begin
        if (sel_valid && (sel != LOCK_CODE)) begin
          pending_next = sel;
          state_next   = ST_WAIT_FRAME;
        end
      end

      ST_SHOW: begin
        if (sel_valid && (sel != active_reg)) begin
          pending_next = sel;
          state_next   = ST_WAIT_FRAME;
        end
      end

      ST_WAIT_FRAME: begin
        pending_next = target;
        if (sel_valid && (sel == active_reg)) begin
          // Request withdrawn before the frame boundary: go back to whatever
          // was being shown. Only the locked screen carries LOCK_CODE.
          state_next = (active_reg == LOCK_CODE) ? ST_LOCKED : ST_SHOW;
        end else if (frame_begin) begin
          if ((target == LOCK_CODE) || (active_reg == LOCK_CODE) || (BLANK_FRAMES == 0)) begin
            active_next = target;
            state_next  = (target == LOCK_CODE) ? ST_LOCKED : ST_SHOW;
          end else begin
            cnt_next   = BLANK_LOAD;
            state_next = ST_BLANK;
          end
        end
      end

      ST_BLANK: begin
        pending_next = target;
        if (frame_begin) begin
          if (cnt_reg > CNT_ONE) begin
            cnt_next = cnt_reg - CNT_ONE;
          end else begin
            active_next = target;
            state_next  = (target == LOCK_CODE) ? ST_LOCKED : ST_SHOW;
          end
        end
      end

      default: begin
        state_next = ST_LOCKED;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: output logic
  // Outputs are derived from the *next* state so that the pixel present on the
  // committing frame_begin cycle is the first one shown one cycle later.
  // ---------------------------------------------------------------------------
  logic [15:0] pix_sel;
  logic [3:0]  an_sel;
  logic [7:0]  seg_sel;
  logic        seg_off;
  logic        show_src;

  always_comb begin
    pix_sel = BLANK_PIXEL;
    an_sel  = BLANK_ANODES;
    seg_sel = BLANK_SEGS;
    seg_off = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active_next == SEL_W'(i)) begin
        pix_sel = src_pix[i];
        an_sel  = src_an[i];
        seg_sel = src_seg[i];
        seg_off = SEG_OFF_MASK[i];
      end
    end

    // While waiting for the boundary the previous picture stays up; that is a
    // live source unless the wait started from the locked screen.
    show_src = (state_next == ST_SHOW) ||
               ((state_next == ST_WAIT_FRAME) && (active_next != LOCK_CODE));

    oled_next = BLANK_PIXEL;
    an_next   = BLANK_ANODES;
    seg_next  = BLANK_SEGS;
    if (show_src) begin
      oled_next = pix_sel;
      if (!seg_off) begin
        an_next  = an_sel;
        seg_next = seg_sel;
      end
    end
`ifdef DISPLAY_FADE_EN
    else if (state_next == ST_BLANK) begin
      oled_next = fade_pixel(pix_sel, BLANK_FRAMES - int'(cnt_next) + 1);
    end
`endif

    switching_next = (state_next == ST_WAIT_FRAME) || (state_next == ST_BLANK);
    sel_err_next   = !sel_valid;
  end

  assign oled_data  = oled_reg;
  assign an         = an_reg;
  assign seg        = seg_reg;
  assign active_src = active_reg;
  assign switching  = switching_reg;
  assign sel_err    = sel_err_reg;

endmodule

// File: tb/tb_display_source_mux.sv
// -----------------------------------------------------------------------------
// tb_display_source_mux
//
// Directed stimulus for display_source_mux with literal expectations at the
// interesting points, plus a reference model (what should be on screen, which
// code is wanted, how many blank frames remain) compared against the DUT on
// every falling clock edge. Ends with a short pseudo-random run.
// -----------------------------------------------------------------------------
module tb_display_source_mux;

  localparam int                NSRC = 10;
  localparam int                BF   = 2;
  localparam logic [NSRC-1:0]   MASK = 10'h080;  // source 7 blanks the 7-seg
  localparam int                LOCK = 15;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [3:0]           sel;
  logic                 frame_begin;
  logic [16*NSRC-1:0]   oled_in;
  logic [4*NSRC-1:0]    an_in;
  logic [8*NSRC-1:0]    seg_in;
  logic [15:0]          oled_data;
  logic [3:0]           an;
  logic [7:0]           seg;
  logic [3:0]           active_src;
  logic                 switching;
  logic                 sel_err;

  int checks   = 0;
  int failures = 0;
  bit vary     = 1'b0;

  always #5 clk = ~clk;

  display_source_mux #(
    .NUM_SRC      (NSRC),
    .SEL_W        (4),
    .LOCK_CODE    (4'hF),
    .BLANK_FRAMES (BF),
    .SEG_OFF_MASK (MASK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .frame_begin (frame_begin),
    .oled_in     (oled_in),
    .an_in       (an_in),
    .seg_in      (seg_in),
    .oled_data   (oled_data),
    .an          (an),
    .seg         (seg),
    .active_src  (active_src),
    .switching   (switching),
    .sel_err     (sel_err)
  );

  // ---------------------------------------------------------------------------
  // Reference model. mode: 0 = steady picture, 1 = change requested, waiting
  // for a frame boundary, 2 = inside the blank frames.
  // ---------------------------------------------------------------------------
  typedef struct {
    int          cur;
    int          want;
    int          mode;
    int          left;
    logic [15:0] oled;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        sw;
    logic        err;
  } model_t;

  model_t m;
  bit     mv = 1'b0;

  function automatic logic [15:0] faded(input logic [15:0] p, input int sh);
    int r, g, b;
    r = int'(p[15:11]) / (1 << sh);
    g = int'(p[10:5])  / (1 << sh);
    b = int'(p[4:0])   / (1 << sh);
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  function automatic model_t model_step(input model_t o, input logic rst, input logic [3:0] s,
                                        input logic fb, input logic [16*NSRC-1:0] oi,
                                        input logic [4*NSRC-1:0] ai, input logic [8*NSRC-1:0] si);
    model_t n;
    bit     ok;
    int     w;
    n = o;
    if (rst) begin
      n.cur = LOCK; n.want = LOCK; n.mode = 0; n.left = 0; n.err = 1'b0;
    end else begin
      ok    = (int'(s) < NSRC) || (int'(s) == LOCK);
      n.err = !ok;
      w     = ok ? int'(s) : o.want;
      if (o.mode == 0) begin
        if (ok && int'(s) != o.cur) begin n.want = int'(s); n.mode = 1; end
      end else if (o.mode == 1) begin
        n.want = w;
        if (ok && int'(s) == o.cur) n.mode = 0;
        else if (fb) begin
          if (w == LOCK || o.cur == LOCK || BF == 0) begin n.cur = w; n.mode = 0; end
          else begin n.mode = 2; n.left = BF; end
        end
      end else begin
        n.want = w;
        if (fb) begin
          if (o.left > 1) n.left = o.left - 1;
          else begin n.cur = w; n.mode = 0; end
        end
      end
    end
    n.sw   = (n.mode != 0);
    n.oled = 16'h0000; n.an = 4'hF; n.seg = 8'hFF;
    if (n.mode == 2) begin
`ifdef DISPLAY_FADE_EN
      if (BF - n.left + 1 < 6) n.oled = faded(oi[16*n.cur +: 16], BF - n.left + 1);
`endif
    end else if (n.cur != LOCK) begin
      n.oled = oi[16*n.cur +: 16];
      if (!MASK[n.cur]) begin
        n.an  = ai[4*n.cur +: 4];
        n.seg = si[8*n.cur +: 8];
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m  <= model_step(m, reset, sel, frame_begin, oled_in, an_in, seg_in);
    mv <= mv | reset;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (mv) begin
        cmp("model_oled",   32'(oled_data),  32'(m.oled));
        cmp("model_an",     32'(an),         32'(m.an));
        cmp("model_seg",    32'(seg),        32'(m.seg));
        cmp("model_active", 32'(active_src), 32'(m.cur));
        cmp("model_switch", 32'(switching),  32'(m.sw));
        cmp("model_selerr", 32'(sel_err),    32'(m.err));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int tick = 0;

  // Static patterns: pixel {A,i,5,i} (source 2 is all-ones for the fade
  // case), anodes i+1, segments {3,i}.
  task automatic load_static();
    for (int i = 0; i < NSRC; i++) begin
      oled_in[16*i +: 16] = {4'hA, 4'(i), 4'h5, 4'(i)};
      an_in[4*i +: 4]     = 4'(i + 1);
      seg_in[8*i +: 8]    = {4'h3, 4'(i)};
    end
    oled_in[16*2 +: 16] = 16'hFFFF;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick++;
    if (vary) begin
      for (int i = 0; i < NSRC; i++) begin
        oled_in[16*i +: 16] = 16'($urandom);
        an_in[4*i +: 4]     = 4'($urandom);
        seg_in[8*i +: 8]    = 8'($urandom);
      end
    end
  endtask

  task automatic fb_step();
    frame_begin = 1'b1;
    step();
    frame_begin = 1'b0;
  endtask

  // Two idle cycles then a frame boundary.
  task automatic frame();
    step();
    step();
    fb_step();
  endtask

  task automatic show_chk(input string tag, input logic [15:0] px, input logic [3:0] a,
                          input logic [7:0] sg, input logic [3:0] act, input logic sw);
    cmp({tag, "_oled"},   32'(oled_data),  32'(px));
    cmp({tag, "_an"},     32'(an),         32'(a));
    cmp({tag, "_seg"},    32'(seg),        32'(sg));
    cmp({tag, "_active"}, 32'(active_src), 32'(act));
    cmp({tag, "_switch"}, 32'(switching),  32'(sw));
  endtask

`ifdef DISPLAY_FADE_EN
  localparam logic [15:0] BLANK1 = 16'h7BEF;
  localparam logic [15:0] BLANK2 = 16'h39E7;
`else
  localparam logic [15:0] BLANK1 = 16'h0000;
  localparam logic [15:0] BLANK2 = 16'h0000;
`endif

  initial begin
    reset = 1'b1; sel = 4'hF; frame_begin = 1'b0;
    oled_in = '0; an_in = '0; seg_in = '0;
    load_static();
    step(); step(); step();
    reset = 1'b0;
    step();
    show_chk("reset", 16'h0000, 4'hF, 8'hFF, 4'hF, 1'b0);
    cmp("reset_selerr", 32'(sel_err), 32'd0);

    // Lock exit: no blank frames, source 0 one cycle after frame_begin.
    sel = 4'd0; step();
    show_chk("lockwait", 16'h0000, 4'hF, 8'hFF, 4'hF, 1'b1);
    step(); step();
    fb_step();
    show_chk("lockexit", 16'hA050, 4'h1, 8'h30, 4'h0, 1'b0);

    // Reach source 2 (two blank frames on the way).
    sel = 4'd2; step();
    show_chk("to2_hold", 16'hA050, 4'h1, 8'h30, 4'h0, 1'b1);
    frame(); frame(); frame();
    show_chk("show2", 16'hFFFF, 4'h3, 8'h32, 4'h2, 1'b0);

    // Source switch 2 -> 5 with exactly two blank frames.
    sel = 4'd5; step(); step(); step();
    show_chk("sw_hold", 16'hFFFF, 4'h3, 8'h32, 4'h2, 1'b1);
    fb_step();
    show_chk("sw_blank1a", BLANK1, 4'hF, 8'hFF, 4'h2, 1'b1);
    step(); step();
    show_chk("sw_blank1b", BLANK1, 4'hF, 8'hFF, 4'h2, 1'b1);
    fb_step();
    show_chk("sw_blank2", BLANK2, 4'hF, 8'hFF, 4'h2, 1'b1);
    step(); step();
    fb_step();
    show_chk("sw_new", 16'hA555, 4'h6, 8'h35, 4'h5, 1'b0);

    // Back to 2, then cancel a 2 -> 5 request.
    sel = 4'd2; step();
    frame(); frame(); frame();
    sel = 4'd5; step();
    cmp("cancel_pend_sw", 32'(switching), 32'd1);
    sel = 4'd2; step();
    show_chk("cancel", 16'hFFFF, 4'h3, 8'h32, 4'h2, 1'b0);
    fb_step();
    show_chk("cancel_fb", 16'hFFFF, 4'h3, 8'h32, 4'h2, 1'b0);

    // Retarget to 7 during blanking, then an invalid code.
    sel = 4'd5; step();
    fb_step();
    sel = 4'd7; step();
    sel = 4'd12; step();
    cmp("err_high", 32'(sel_err), 32'd1);
    fb_step();
    fb_step();
    show_chk("retarget7", 16'hA757, 4'hF, 8'hFF, 4'h7, 1'b0);
    cmp("err_still", 32'(sel_err), 32'd1);

    // Lock from a live source: commit straight to LOCKED on the boundary.
    sel = 4'hF; step();
    cmp("err_low", 32'(sel_err), 32'd0);
    show_chk("tolock_hold", 16'hA757, 4'hF, 8'hFF, 4'h7, 1'b1);
    fb_step();
    show_chk("locked", 16'h0000, 4'hF, 8'hFF, 4'hF, 1'b0);

    // Mid-operation reset while blanking.
    sel = 4'd3; step();
    fb_step();
    show_chk("show3", 16'hA353, 4'h4, 8'h33, 4'h3, 1'b0);
    sel = 4'd4; step();
    fb_step();
    reset = 1'b1; step();
    show_chk("midreset", 16'h0000, 4'hF, 8'hFF, 4'hF, 1'b0);
    reset = 1'b0; sel = 4'hF; step();

    // Pseudo-random run checked by the model only.
    vary = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       sel = 4'hF;
          1:       sel = 4'($urandom_range(10, 14));
          default: sel = 4'($urandom_range(0, 9));
        endcase
      end
      frame_begin = ($urandom_range(0, 4) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; frame_begin = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
